// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request, valid/ready hand-off to decode.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_CHK_EN.
//
// state | meaning
// IDLE  | after reset, first request not yet issued
// FETCH | request outstanding on req_addr, response will be kept
// HOLD  | instruction (or misalign trap) presented to decode
// DROP  | redirected while a request was in flight; drain and discard it
// HALT  | parked after a misaligned trap was consumed; waits for redirect
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_fetch_err
);

  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DROP, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] pc_q, pc_q_nxt;
  logic        err_q, err_nxt;
  logic [31:0] tgt;
  logic        launch;
  logic [31:0] launch_pc;
  logic        launch_bad;

`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt        = i_redirect_pc;
  assign launch_bad = |launch_pc[1:0];
`else
  logic unused_redirect_lsb;
  assign tgt                 = {i_redirect_pc[31:2], 2'b00};
  assign launch_bad          = 1'b0;
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];
`endif

  // "launch" = start a new fetch at launch_pc (or trap it if misaligned).
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    instr_nxt    = instr_q;
    pc_q_nxt     = pc_q;
    err_nxt      = err_q;
    launch       = 1'b0;
    launch_pc    = pc;

    case (state)
      IDLE: begin
        launch    = 1'b1;
        launch_pc = i_redirect ? tgt : pc;
      end
      FETCH: begin
        if (i_redirect) begin
          if (i_imem_ack) begin
            launch    = 1'b1;
            launch_pc = tgt;
          end else begin
            pc_nxt    = tgt;
            state_nxt = DROP;
          end
        end else if (i_imem_ack) begin
          instr_nxt = i_imem_rdata;
          pc_q_nxt  = req_addr;
          pc_nxt    = req_addr + 32'd4;
          state_nxt = HOLD;
        end
      end
      DROP: begin
        if (i_imem_ack) begin
          launch    = 1'b1;
          launch_pc = i_redirect ? tgt : pc;
        end else if (i_redirect) begin
          pc_nxt = tgt;
        end
      end
      HOLD: begin
        if (i_redirect) begin
          launch    = 1'b1;
          launch_pc = tgt;
        end else if (i_ready) begin
          if (err_q) begin
            state_nxt = HALT;
          end else begin
            launch    = 1'b1;
            launch_pc = pc;
          end
        end
      end
      HALT: begin
        if (i_redirect) begin
          launch    = 1'b1;
          launch_pc = tgt;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (launch) begin
      pc_nxt = launch_pc;
      if (launch_bad) begin
        state_nxt = HOLD;
        instr_nxt = NOP_INSTR;
        pc_q_nxt  = launch_pc;
        err_nxt   = 1'b1;
      end else begin
        state_nxt    = FETCH;
        req_addr_nxt = launch_pc;
        err_nxt      = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      pc_q     <= pc_q_nxt;
      instr_q  <= instr_nxt;
      err_q    <= err_nxt;
    end
  end

  assign o_imem_req  = (state == FETCH) || (state == DROP);
  assign o_imem_addr = req_addr;
  assign o_valid     = (state == HOLD);
  assign o_instr     = instr_q;
  assign o_pc        = pc_q;
  assign o_fetch_err = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model returns addr ^ K; expected requests
// and decode outputs are queued by the stimulus and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] K   = 32'h0050_0093;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_fetch_err;

  fetch_stage dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_instr(o_instr), .o_pc(o_pc), .o_fetch_err(o_fetch_err)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  logic [31:0] exp_req_q[$];
  logic [64:0] exp_out_q[$];   // {err, instr, pc}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!o_valid) begin
      errors++;
      $display("FAIL %s: o_valid=%b after %0d cycles, expected 1", name, o_valid, n);
    end
  endtask

  task automatic push_out(input logic err, input logic [31:0] instr, input logic [31:0] pc);
    exp_out_q.push_back({err, instr, pc});
  endtask

  // memory model: ack after mem_lat wait cycles, data = addr ^ K
  initial forever begin
    @(posedge i_clk);
    #1;
    if (i_rst) begin
      wait_cnt   = 0;
      i_imem_ack = 1'b0;
    end else begin
      if (i_imem_ack) wait_cnt = 0;
      i_imem_ack = 1'b0;
      if (o_imem_req) begin
        if (wait_cnt >= mem_lat) begin
          i_imem_ack   = 1'b1;
          i_imem_rdata = o_imem_addr ^ K;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // monitor
  initial begin
    logic        prev_req, prev_ack, prev_valid, prev_ready;
    logic [31:0] prev_addr, prev_instr, prev_pc;
    logic [64:0] e;
    prev_req = 0; prev_ack = 0; prev_valid = 0; prev_ready = 0;
    prev_addr = 0; prev_instr = 0; prev_pc = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_imem_req && i_imem_ack) begin
          if (exp_req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got addr %h expected no request", o_imem_addr);
          end else begin
            check("req_addr", o_imem_addr, exp_req_q.pop_front());
          end
        end
        if (prev_req && !prev_ack && o_imem_req)
          check("req_stable", o_imem_addr, prev_addr);
        if (prev_valid && !prev_ready && o_valid) begin
          check("hold_instr_stable", o_instr, prev_instr);
          check("hold_pc_stable", o_pc, prev_pc);
        end
        if (o_valid && i_ready) begin
          if (exp_out_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_unexpected: got pc %h expected no instruction", o_pc);
          end else begin
            e = exp_out_q.pop_front();
            check("out_instr", o_instr, e[63:32]);
            check("out_pc", o_pc, e[31:0]);
            check("out_err", {31'b0, o_fetch_err}, {31'b0, e[64]});
          end
        end
      end
      prev_req = o_imem_req; prev_ack = i_imem_ack; prev_addr = o_imem_addr;
      prev_valid = o_valid; prev_ready = i_ready; prev_instr = o_instr; prev_pc = o_pc;
    end
  end

  initial begin
    // reset
    tick(); tick();
    check("rst_req", {31'b0, o_imem_req}, 32'h0);
    check("rst_valid", {31'b0, o_valid}, 32'h0);
    check("rst_instr", o_instr, NOP);
    check("rst_pc", o_pc, 32'h0);
    check("rst_err", {31'b0, o_fetch_err}, 32'h0);

    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8);
    exp_req_q.push_back(32'hC);
    exp_req_q.push_back(32'h100);
    exp_req_q.push_back(32'h200);
    exp_req_q.push_back(32'hFFFF_FFFC);
    exp_req_q.push_back(32'h0);
    push_out(1'b0, 32'h0050_0093, 32'h0);
    push_out(1'b0, 32'h0050_0097, 32'h4);
    push_out(1'b0, 32'h0050_009B, 32'h8);
    push_out(1'b0, 32'h0050_0193, 32'h100);
    push_out(1'b0, 32'h0050_0293, 32'h200);
    push_out(1'b0, 32'hFFAF_FF6F, 32'hFFFF_FFFC);
    push_out(1'b0, 32'h0050_0093, 32'h0);

    // zero-wait memory, ready high
    i_rst   = 1'b0;
    i_ready = 1'b1;
    tick();
    check("first_req", {31'b0, o_imem_req}, 32'h1);
    check("first_addr", o_imem_addr, 32'h0);
    wait_valid("first_valid");
    tick();
    check("second_addr", o_imem_addr, 32'h4);

    // backpressure on pc=4
    i_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, o_valid}, 32'h1);
      check("bp_noreq", {31'b0, o_imem_req}, 32'h0);
      check("bp_pc", o_pc, 32'h4);
      tick();
    end
    i_ready = 1'b1;
    tick();
    check("bp_next_req", {31'b0, o_imem_req}, 32'h1);
    check("bp_next_addr", o_imem_addr, 32'h8);

    // slow memory, redirect during first wait cycle of request to 0xC
    mem_lat = 2;
    tick();
    tick();
    check("slow_addr", o_imem_addr, 32'hC);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h100;
    tick();
    i_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("drop_req", {31'b0, o_imem_req}, 32'h1);
      check("drop_addr", o_imem_addr, 32'hC);
      check("drop_valid", {31'b0, o_valid}, 32'h0);
      tick();
    end
    check("after_drop_addr", o_imem_addr, 32'h100);
    check("after_drop_valid", {31'b0, o_valid}, 32'h0);
    wait_valid("redir_valid");

    // redirect in HOLD with ready high
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    tick();
    i_redirect = 1'b0;
    mem_lat    = 0;
    check("hold_redir_valid", {31'b0, o_valid}, 32'h0);
    check("hold_redir_addr", o_imem_addr, 32'h200);
    wait_valid("r200_valid");

    // PC wrap
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    check("wrap_req_addr", o_imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap_valid");
    tick();
    check("wrap_next_addr", o_imem_addr, 32'h0);
    wait_valid("wrap0_valid");

    // misaligned redirect
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h102;
`ifdef FETCH_MISALIGN_CHK_EN
    push_out(1'b1, NOP, 32'h102);
    tick();
    i_redirect = 1'b0;
    check("mis_noreq", {31'b0, o_imem_req}, 32'h0);
    check("mis_valid", {31'b0, o_valid}, 32'h1);
    check("mis_err", {31'b0, o_fetch_err}, 32'h1);
    check("mis_pc", o_pc, 32'h102);
    check("mis_instr", o_instr, NOP);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("halt_noreq", {31'b0, o_imem_req}, 32'h0);
      check("halt_valid", {31'b0, o_valid}, 32'h0);
      tick();
    end
    exp_req_q.push_back(32'h300);
    push_out(1'b0, 32'h0050_0393, 32'h300);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h300;
    tick();
    i_redirect = 1'b0;
    i_ready    = 1'b0;
    check("unhalt_addr", o_imem_addr, 32'h300);
    check("unhalt_err", {31'b0, o_fetch_err}, 32'h0);
    wait_valid("unhalt_valid");
`else
    exp_req_q.push_back(32'h100);
    push_out(1'b0, 32'h0050_0193, 32'h100);
    tick();
    i_redirect = 1'b0;
    i_ready    = 1'b0;
    check("mis_req", {31'b0, o_imem_req}, 32'h1);
    check("mis_addr", o_imem_addr, 32'h100);
    check("mis_err", {31'b0, o_fetch_err}, 32'h0);
    wait_valid("mis_valid");
`endif

    // consume last instruction, then reset before the following fetch is checked
    i_ready = 1'b1;
    tick();
    i_rst = 1'b1;
    tick();
    tick();
    check("req_queue_empty", exp_req_q.size(), 32'h0);
    check("out_queue_empty", exp_out_q.size(), 32'h0);
    check("end_rst_req", {31'b0, o_imem_req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation reached 20000ns, expected earlier finish");
    $fatal(1, "timeout");
  end
endmodule
